// File: rtl/pad_ring_ctrl.sv
// rtl/pad_ring_ctrl.sv - pad-ring control: input sync, debounce filter, edge/irq status, output drive
module pad_ring_ctrl #(
  parameter int                 NUM_CH      = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 FILT_W      = 8,
  parameter logic [NUM_CH-1:0]  IN_RST_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              testmode_i,
  input  logic [NUM_CH-1:0] pad_in_i,
  output logic [NUM_CH-1:0] pad_out_o,
  output logic [NUM_CH-1:0] pad_oe_o,
  input  logic [NUM_CH-1:0] core_out_i,
  input  logic [NUM_CH-1:0] core_oe_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic [NUM_CH-1:0] core_in_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  input  logic [NUM_CH-1:0] evt_clr_i,
  input  logic [NUM_CH-1:0] irq_mask_i,
  output logic [NUM_CH-1:0] evt_sts_o,
  output logic              irq_o
);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [FILT_W-1:0] cnt    [NUM_CH];
  logic [NUM_CH-1:0] filt_d;
  logic [NUM_CH-1:0] sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_out_o <= '0;
      pad_oe_o  <= '0;
    end else begin
      pad_out_o <= core_out_i;
      pad_oe_o  <= core_oe_i & ~{NUM_CH{testmode_i}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RST_VAL;
    end else begin
      sync_q[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Counter only advances while sync disagrees with the filtered value; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in_o <= IN_RST_VAL;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (testmode_i) begin
          core_in_o[i] <= sync[i];
          cnt[i]       <= '0;
        end else if (sync[i] == core_in_o[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= filt_len_i) begin
          core_in_o[i] <= sync[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + FILT_W'(1);
        end
      end
    end
  end

  // filt_d resets to the same value as core_in_o so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_d    <= IN_RST_VAL;
      rise_o    <= '0;
      fall_o    <= '0;
      evt_sts_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      filt_d    <= core_in_o;
      rise_o    <= core_in_o & ~filt_d;
      fall_o    <= ~core_in_o & filt_d;
      evt_sts_o <= (evt_sts_o & ~evt_clr_i) | rise_o | fall_o;
      irq_o     <= |(evt_sts_o & irq_mask_i);
    end
  end

endmodule
